// File: rtl/a2d_pkg.sv
// Shared types and constants for the ADC128S SPI master.
package a2d_pkg;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER1 = 2'd1,
    PAUSE = 2'd2,
    XFER2 = 2'd3
  } a2d_state_e;

  // Channel field position inside the 16-bit command word.
  localparam int CMD_CH_LSB = 11;

  // Divider value held while SS_n is high (10111 for a 5-bit divider).
  function automatic int sclk_preload(input int w);
    return (2 ** (w - 1)) + (2 ** (w - 2)) - 1;
  endfunction

  // Divider value on the clk before SCLK rises (MISO sample point).
  function automatic int sclk_rise_val(input int w);
    return (2 ** (w - 1)) - 1;
  endfunction

  // Divider value on the clk before SCLK falls (shift point).
  function automatic int sclk_fall_val(input int w);
    return (2 ** w) - 1;
  endfunction

  // Command word: {2'b00, channel, 11'h000}.
  function automatic logic [15:0] mk_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_spi_mstr_xfer.sv
// spi_xfer16: one 16-bit SPI mode-0 transaction. Generates SS_n and SCLK,
// shifts the command out on MOSI, samples MISO and pulses o_done after the
// clk on which SS_n returns high.
module spi_xfer16
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [15:0] i_tx_word,
  input  logic        i_miso,
  output logic        o_ss_n,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_done,
  output logic [11:0] o_rx_low
);

  localparam logic [SCLK_DIV_W-1:0] DIV_PRELOAD = SCLK_DIV_W'(sclk_preload(SCLK_DIV_W));
  localparam logic [SCLK_DIV_W-1:0] DIV_START   = SCLK_DIV_W'(sclk_preload(SCLK_DIV_W) + 1);
  localparam logic [SCLK_DIV_W-1:0] DIV_RISE    = SCLK_DIV_W'(sclk_rise_val(SCLK_DIV_W));
  localparam logic [SCLK_DIV_W-1:0] DIV_FALL    = SCLK_DIV_W'(sclk_fall_val(SCLK_DIV_W));

  logic [SCLK_DIV_W-1:0] r_sclk_div;
  logic                  r_ss_n;
  logic [15:0]           r_shift;
  logic [4:0]            r_smpl_cnt;
  logic                  r_miso_smpl;
  logic                  r_done;

  logic w_active;
  logic w_rise_imm;
  logic w_fall_imm;
  logic w_last_fall;

  assign w_active    = ~r_ss_n;
  assign w_rise_imm  = w_active & (r_sclk_div == DIV_RISE);
  assign w_fall_imm  = w_active & (r_sclk_div == DIV_FALL);
  // First fall-point after the 16th sample ends the transaction.
  assign w_last_fall = w_fall_imm & (r_smpl_cnt == 5'd16);

  // Slave select and SCLK divider; divider rests at the preload while SS_n is
  // high and advances from the clk SS_n falls, so SCLK idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_n     <= 1'b1;
      r_sclk_div <= DIV_PRELOAD;
    end else if (w_active) begin
      if (w_last_fall) begin
        r_ss_n     <= 1'b1;
        r_sclk_div <= DIV_PRELOAD;
      end else begin
        r_sclk_div <= r_sclk_div + SCLK_DIV_W'(1);
      end
    end else if (i_start) begin
      r_ss_n     <= 1'b0;
      r_sclk_div <= DIV_START;
    end else begin
      r_sclk_div <= DIV_PRELOAD;
    end
  end

  // Shift register: load on start, sample MISO before each rise, shift on
  // each fall-point except the one preceding the first sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= 16'h0000;
      r_smpl_cnt  <= 5'd0;
      r_miso_smpl <= 1'b0;
    end else if (!w_active) begin
      if (i_start) begin
        r_shift    <= i_tx_word;
        r_smpl_cnt <= 5'd0;
      end
    end else begin
      if (w_rise_imm) begin
        r_miso_smpl <= i_miso;
        r_smpl_cnt  <= r_smpl_cnt + 5'd1;
      end
      if (w_fall_imm && (r_smpl_cnt != 5'd0)) begin
        r_shift <= {r_shift[14:0], r_miso_smpl};
      end
    end
  end

  // Done pulse, one clk after SS_n rises, when the final bit is in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last_fall;
    end
  end

  assign o_ss_n   = r_ss_n;
  assign o_sclk   = r_sclk_div[SCLK_DIV_W-1];
  assign o_mosi   = r_shift[15];
  assign o_done   = r_done;
  assign o_rx_low = r_shift[11:0];

endmodule

// File: rtl/a2d_spi_mstr.sv
// a2d_spi_mstr: ADC128S conversion sequencer. Runs a command transaction and a
// result transaction per conversion, then holds the 12-bit result on res.
// Optional feature macro: A2D_CONT_CONV_EN adds the cont input, which makes
// the block restart on the same channel after each result.
module a2d_spi_mstr
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5,
  parameter int PAUSE_CLKS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  input  logic        MISO,
`ifdef A2D_CONT_CONV_EN
  input  logic        cont,
`endif
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        cnv_cmplt,
  output logic [11:0] res
);

  // The restart request is issued on the clk that would otherwise enter PAUSE,
  // so PAUSE holds PAUSE_CLKS-2 clks (the done pulse and start register add 2).
  localparam int PAUSE_LAST_I = (PAUSE_CLKS > 3) ? (PAUSE_CLKS - 3) : 0;
  localparam int PAUSE_CNT_W  = (PAUSE_CLKS > 2) ? $clog2(PAUSE_CLKS) : 1;
  localparam logic [PAUSE_CNT_W-1:0] PAUSE_LAST = PAUSE_CNT_W'(PAUSE_LAST_I);

  a2d_state_e             r_state;
  a2d_state_e             w_state_nxt;
  logic [15:0]            r_cmd;
  logic                   r_start;
  logic                   r_restart;
  logic [PAUSE_CNT_W-1:0] r_pause_cnt;
  logic                   r_cnv_cmplt;
  logic [11:0]            r_res;

  logic        w_start_nxt;
  logic        w_accept;
  logic        w_pause_clr;
  logic        w_res_ld;
  logic        w_restart_nxt;
  logic        w_cont;
  logic        w_done;
  logic [11:0] w_rx_low;

`ifdef A2D_CONT_CONV_EN
  assign w_cont = cont;
`else
  assign w_cont = 1'b0;
`endif

  spi_xfer16 #(
    .SCLK_DIV_W (SCLK_DIV_W)
  ) u_xfer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (r_start),
    .i_tx_word (r_cmd),
    .i_miso    (MISO),
    .o_ss_n    (SS_n),
    .o_sclk    (SCLK),
    .o_mosi    (MOSI),
    .o_done    (w_done),
    .o_rx_low  (w_rx_low)
  );

  // State register and registered transaction-start request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_start   <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start   <= w_start_nxt;
      r_restart <= w_restart_nxt;
    end
  end

  // Next-state logic: command transaction, pause, result transaction.
  always_comb begin
    w_state_nxt   = r_state;
    w_start_nxt   = 1'b0;
    w_accept      = 1'b0;
    w_pause_clr   = 1'b0;
    w_res_ld      = 1'b0;
    w_restart_nxt = r_restart;
    case (r_state)
      IDLE: begin
        if (strt_cnv) begin
          w_accept      = 1'b1;
          w_start_nxt   = 1'b1;
          w_restart_nxt = 1'b0;
          w_state_nxt   = XFER1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      XFER1: begin
        if (w_done) begin
          w_restart_nxt = 1'b0;
          if (PAUSE_CLKS <= 2) begin
            w_start_nxt = 1'b1;
            w_state_nxt = XFER2;
          end else begin
            w_pause_clr = 1'b1;
            w_state_nxt = PAUSE;
          end
        end else begin
          w_state_nxt = XFER1;
        end
      end
      PAUSE: begin
        if (r_pause_cnt == PAUSE_LAST) begin
          w_start_nxt = 1'b1;
          w_state_nxt = r_restart ? XFER1 : XFER2;
        end else begin
          w_state_nxt = PAUSE;
        end
      end
      XFER2: begin
        if (w_done) begin
          w_res_ld = 1'b1;
          if (w_cont) begin
            w_restart_nxt = 1'b1;
            if (PAUSE_CLKS <= 2) begin
              w_start_nxt = 1'b1;
              w_state_nxt = XFER1;
            end else begin
              w_pause_clr = 1'b1;
              w_state_nxt = PAUSE;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = XFER2;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Pause length counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pause_cnt <= '0;
    end else if (w_pause_clr) begin
      r_pause_cnt <= '0;
    end else if (r_state == PAUSE) begin
      r_pause_cnt <= r_pause_cnt + PAUSE_CNT_W'(1);
    end else begin
      r_pause_cnt <= r_pause_cnt;
    end
  end

  // Command latch: the channel is captured only when a conversion is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= 16'h0000;
    end else if (w_accept) begin
      r_cmd <= mk_cmd(chnnl);
    end else begin
      r_cmd <= r_cmd;
    end
  end

  // Result and completion flag; cleared on accept or on an auto-restart SS_n fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res       <= 12'h000;
      r_cnv_cmplt <= 1'b0;
    end else if (w_res_ld) begin
      r_res       <= w_rx_low;
      r_cnv_cmplt <= 1'b1;
    end else if (w_accept || (r_start && (r_state == XFER1))) begin
      r_cnv_cmplt <= 1'b0;
    end else begin
      r_cnv_cmplt <= r_cnv_cmplt;
    end
  end

  assign cnv_cmplt = r_cnv_cmplt;
  assign res       = r_res;

endmodule
